// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the debounce_sync block: FSM state encoding and
// the qualification counter width derivation.
package debounce_sync_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    // A single-cycle qualification still needs a one-bit counter.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous pin; all stages clear to 0.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw pin in at bit 0 towards the output stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    // Synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw pin into a clean level with one-cycle
// rise/fall pulses; dout feeds the downstream capture register.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .din   (din),
        .s     (s)
    );

    // Next-state logic: a level change must hold for STABLE_CYCLES enabled
    // edges; any reversion in between aborts regardless of en.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE_LO;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HI;
                        cnt_d   = CNT_ZERO;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE_HI;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_LO;
                        cnt_d   = CNT_ZERO;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = CNT_ZERO;
                dout_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE_LO;
            cnt_q   <= CNT_ZERO;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync at default parameters; output vector is
// {dout, rise, fall, busy}.
module tb_debounce_sync;

    logic clk;
    logic rst;
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int checks_s   = 0;
    int failures_s = 0;

    debounce_sync #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_s++;
        if (obs !== exp) begin
            failures_s++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {4'b0000, dout, rise, fall, busy};
    endfunction

    // exp holds one nibble per edge, edge 1 in the top nibble.
    task automatic run_table(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("%s_e%0d", tag, i + 1), outs(), {4'b0000, exp[31-4*i -: 4]});
        end
    endtask

    localparam logic [31:0] RISE_TBL = 32'h001111C8;
    localparam logic [31:0] FALL_TBL = 32'h88999920;

    initial begin
        logic rise_seen;
        logic dout_seen;
        rst = 1'b0;
        din = 1'b0;
        en  = 1'b1;

        // Reset state, asserted from time zero.
        #2;
        chk("reset_t0", outs(), 8'h00);
        step();
        step();
        chk("reset_held", outs(), 8'h00);
        rst = 1'b1;
        step();
        chk("idle_after_release", outs(), 8'h00);

        // Clean rise.
        din = 1'b1;
        run_table("rise", RISE_TBL);
        step();
        chk("rise_hold", outs(), 8'h08);

        // Clean fall.
        din = 1'b0;
        run_table("fall", FALL_TBL);

        // Bounce: din high across three edges, then low again.
        din       = 1'b1;
        rise_seen = 1'b0;
        dout_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) din = 1'b0;
            step();
            rise_seen = rise_seen | rise;
            dout_seen = dout_seen | dout;
            if (k == 5) chk("bounce_busy_e5", {7'd0, busy}, 8'h01);
            if (k == 6) chk("bounce_busy_e6", {7'd0, busy}, 8'h00);
        end
        chk("bounce_no_rise", {7'd0, rise_seen}, 8'h00);
        chk("bounce_no_dout", {7'd0, dout_seen}, 8'h00);

        // Gated enable: en high on odd edges only; WAIT_HI entered at edge 3.
        din = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            en = (k % 2 == 1) ? 1'b1 : 1'b0;
            step();
            if (k == 7)  chk("gated_e7",  outs(), 8'h01);
            if (k == 10) chk("gated_e10", outs(), 8'h01);
            if (k == 11) chk("gated_e11", outs(), 8'h0C);
            if (k == 12) chk("gated_e12", outs(), 8'h08);
        end
        en = 1'b1;

        // Mid-cycle reset with dout=1 and din=1.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midcycle_reset", outs(), 8'h00);
        step();
        step();
        chk("midcycle_reset_held", outs(), 8'h00);
        rst = 1'b1;
        run_table("relrise", RISE_TBL);

        // Return to dout=0, then reset while qualifying a rise.
        din = 1'b0;
        run_table("fall2", FALL_TBL);
        din = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        chk("midq_busy_pre", outs(), 8'h01);
        rst = 1'b0;
        #1;
        chk("midq_busy_drop", outs(), 8'h00);
        step();
        rst = 1'b1;
        run_table("midq_rise", RISE_TBL);

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule
